// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator.
package wb_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP,
    ST_FIN
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;
  localparam logic [1:0] ERR_ALIGN   = 2'd3;

  localparam logic [3:0]  SEL_ALL    = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/wb_copy_timeout.sv
// Per-transaction wait counter; expired fires on the TIMEOUT-th cycle of a
// strobe so the bus can drop on the following cycle.
module wb_copy_timeout #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = en && (cnt_reg == LAST);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator copying cfg_len words from cfg_src to cfg_dst,
// one read then one write per word, with an idle bus cycle between transactions.
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             sts_busy,
  output logic             sts_done,
  output logic [1:0]       sts_err,
  output logic [LEN_W-1:0] sts_count,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic [31:0]      data_reg, data_next;
  logic [1:0]       err_reg, err_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             cyc_reg, cyc_next;
  logic             we_reg, we_next;
  logic [3:0]       sel_reg, sel_next;
  logic [31:0]      adr_reg, adr_next;
  logic [31:0]      dat_o_reg, dat_o_next;

  logic             waiting;
  logic             to_expired;
  logic [LEN_W-1:0] count_inc;

  assign waiting   = (state_reg == ST_RD) || (state_reg == ST_WR);
  assign count_inc = count_reg + LEN_W'(1);

  // Counter is held clear outside RD/WR, so every strobe starts from zero.
  wb_copy_timeout #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting),
    .en      (waiting),
    .expired (to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      err_reg   <= ERR_OK;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      adr_reg   <= '0;
      dat_o_reg <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      cyc_reg   <= cyc_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      adr_reg   <= adr_next;
      dat_o_reg <= dat_o_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    len_next   = len_reg;
    count_next = count_reg;
    data_next  = data_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    cyc_next   = cyc_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    adr_next   = adr_reg;
    dat_o_next = dat_o_reg;

    // Abort beats timeout beats ack; FIN is already on its way out.
    if (state_reg != ST_IDLE && state_reg != ST_FIN && cfg_abort) begin
      err_next   = ERR_ABORT;
      state_next = ST_FIN;
      cyc_next   = 1'b0;
      we_next    = 1'b0;
      sel_next   = '0;
    end else if (waiting && to_expired) begin
      err_next   = ERR_TIMEOUT;
      state_next = ST_FIN;
      cyc_next   = 1'b0;
      we_next    = 1'b0;
      sel_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cfg_start) begin
            if (!is_word_aligned(cfg_src) || !is_word_aligned(cfg_dst)) begin
              err_next  = ERR_ALIGN;
              done_next = 1'b1;
            end else if (cfg_len == '0) begin
              err_next  = ERR_OK;
              done_next = 1'b1;
            end else begin
              src_next   = cfg_src;
              dst_next   = cfg_dst;
              len_next   = cfg_len;
              count_next = '0;
              err_next   = ERR_OK;
              state_next = ST_RD;
              cyc_next   = 1'b1;
              we_next    = 1'b0;
              sel_next   = '0;
              adr_next   = cfg_src;
            end
          end
        end
        ST_RD: begin
          if (wbm_ack_i) begin
            data_next  = wbm_dat_i;
            cyc_next   = 1'b0;
            state_next = ST_RD_GAP;
          end
        end
        ST_RD_GAP: begin
          state_next = ST_WR;
          cyc_next   = 1'b1;
          we_next    = 1'b1;
          sel_next   = SEL_ALL;
          adr_next   = dst_reg;
          dat_o_next = data_reg;
        end
        ST_WR: begin
          if (wbm_ack_i) begin
            count_next = count_inc;
            src_next   = src_reg + WORD_BYTES;
            dst_next   = dst_reg + WORD_BYTES;
            cyc_next   = 1'b0;
            we_next    = 1'b0;
            sel_next   = '0;
            state_next = (count_inc == len_reg) ? ST_FIN : ST_WR_GAP;
          end
        end
        ST_WR_GAP: begin
          state_next = ST_RD;
          cyc_next   = 1'b1;
          we_next    = 1'b0;
          sel_next   = '0;
          adr_next   = src_reg;
        end
        ST_FIN: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          cyc_next   = 1'b0;
          we_next    = 1'b0;
          sel_next   = '0;
        end
      endcase
    end

    if (state_next == ST_FIN) begin
      done_next = 1'b1;
    end
  end

  assign busy_next = (state_next != ST_IDLE);

  assign sts_busy  = busy_reg;
  assign sts_done  = done_reg;
  assign sts_err   = err_reg;
  assign sts_count = count_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_sel_o = sel_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_o_reg;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: a responder with programmable ack delays plus a
// transaction-level model of the expected copy sequence, checked every cycle.
module tb_wb_copy_master;

  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_abort;
  logic [31:0]      cfg_src, cfg_dst;
  logic [LEN_W-1:0] cfg_len;
  logic             sts_busy, sts_done;
  logic [1:0]       sts_err;
  logic [LEN_W-1:0] sts_count;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic             wbm_ack_i;

  always #5 clk = ~clk;

  wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err), .sts_count(sts_count),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  // ---------------- responder ----------------
  int          rd_delay = 2, wr_delay = 0, age = 0;
  bit          resp_en = 1'b1, force_ack = 1'b0;
  logic [31:0] seed = 32'h0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  logic resp_ack;
  assign resp_ack  = resp_en && wbm_stb_o && (age >= (wbm_we_o ? wr_delay : rd_delay));
  assign wbm_ack_i = resp_ack | force_ack;
  assign wbm_dat_i = (wbm_stb_o && !wbm_we_o) ? data_of(wbm_adr_o) : 32'hDEAD_BEEF;

  always @(posedge clk) age <= (wbm_stb_o && !wbm_ack_i) ? age + 1 : 0;

  // ---------------- model and checker ----------------
  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_q[$];
  int          n_chk = 0, n_pass = 0;
  int          exp_count = 0, done_cnt = 0, cyc_seen = 0;
  int          stb_run = 0, last_run = 0, n_txn = 0, n_wr = 0;
  bit          mon_en = 1'b0, prev_end = 1'b0;
  logic [31:0] last_wr_adr = '0, first_wr_dat = '0, last_wr_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      txn_t e;
      chk("cyc_eq_stb", 32'(wbm_cyc_o), 32'(wbm_stb_o));
      if (wbm_cyc_o) begin
        cyc_seen++;
        chk("sel", 32'(wbm_sel_o), wbm_we_o ? 32'hF : 32'h0);
      end
      if (prev_end) chk("bus_gap", 32'(wbm_cyc_o), 32'h0);
      chk("count", 32'(sts_count), 32'(exp_count));
      if (sts_done) done_cnt++;
      if (wbm_stb_o) stb_run++;
      else begin
        if (stb_run != 0) last_run = stb_run;
        stb_run = 0;
      end
      prev_end = 1'b0;
      if (wbm_stb_o && cfg_abort) begin
        prev_end = 1'b1;
      end else if (wbm_stb_o && wbm_ack_i && age < TIMEOUT - 1) begin
        prev_end = 1'b1;
        n_txn++;
        chk("txn_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("txn_we", 32'(wbm_we_o), 32'(e.we));
          chk("txn_adr", wbm_adr_o, e.adr);
          if (e.we) begin
            chk("txn_wdat", wbm_dat_o, e.dat);
            exp_count++;
            n_wr++;
            if (n_wr == 1) first_wr_dat = wbm_dat_o;
            last_wr_dat = wbm_dat_o;
            last_wr_adr = wbm_adr_o;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input int len, input bit fill, input bit accepted);
    if (fill) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{we: 1'b0, adr: s + 32'(4 * i), dat: 32'h0});
        exp_q.push_back('{we: 1'b1, adr: d + 32'(4 * i), dat: data_of(s + 32'(4 * i))});
      end
    end
    done_cnt  = 0;
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = LEN_W'(len);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    if (accepted) exp_count = 0;
  endtask

  task automatic finish_run(input string name, input logic [1:0] err, input int cnt, input bit want_empty);
    bit seen = 1'b0;
    for (int n = 0; n < 5000 && !seen; n++) begin
      @(negedge clk);
      seen = sts_done;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'h1);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(sts_busy), 32'h0);
    chk({name, "_done_once"}, 32'(sts_done), 32'h0);
    repeat (2) @(negedge clk);
    chk({name, "_err"}, 32'(sts_err), 32'(err));
    chk({name, "_count"}, 32'(sts_count), 32'(cnt));
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'h1);
    if (want_empty) chk({name, "_all_txn"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d;
    int len;
    bit hit;

    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'h0);
    chk("rst_stb", 32'(wbm_stb_o), 32'h0);
    chk("rst_we", 32'(wbm_we_o), 32'h0);
    chk("rst_sel", 32'(wbm_sel_o), 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_busy", 32'(sts_busy), 32'h0);
    chk("rst_done", 32'(sts_done), 32'h0);
    chk("rst_err", 32'(sts_err), 32'h0);
    chk("rst_count", 32'(sts_count), 32'h0);
    tick();
    rst = 1'b0;
    exp_count = 0;
    mon_en = 1'b1;
    tick();

    // Directed copy of three words into the input-data window.
    seed = 32'h0; rd_delay = 2; wr_delay = 0; n_txn = 0; n_wr = 0;
    start(32'h3800_0000, 32'h3800_4000, 3, 1'b1, 1'b1);
    finish_run("directed", 2'd0, 3, 1'b1);
    chk("directed_ntxn", 32'(n_txn), 32'd6);
    chk("directed_last_adr", last_wr_adr, 32'h3800_4008);
    chk("directed_first_dat", first_wr_dat, 32'hB800_0000);
    chk("directed_last_dat", last_wr_dat, 32'hA9BB_CD88);

    // Zero length: done next cycle, no bus activity.
    cyc_seen = 0;
    start(32'h3800_0000, 32'h3800_4000, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("len0_done", 32'(sts_done), 32'h1);
    chk("len0_err", 32'(sts_err), 32'h0);
    chk("len0_busy", 32'(sts_busy), 32'h0);
    repeat (3) @(negedge clk);
    chk("len0_no_cyc", 32'(cyc_seen), 32'h0);
    chk("len0_done_cnt", 32'(done_cnt), 32'h1);
    tick();

    // Misaligned source, then misaligned destination.
    for (int k = 0; k < 2; k++) begin
      cyc_seen = 0;
      start(k == 0 ? 32'h3800_0002 : 32'h3800_0000, k == 0 ? 32'h3800_4000 : 32'h3800_4001, 2, 1'b0, 1'b0);
      @(negedge clk);
      chk("align_done", 32'(sts_done), 32'h1);
      chk("align_err", 32'(sts_err), 32'h3);
      repeat (3) @(negedge clk);
      chk("align_err_held", 32'(sts_err), 32'h3);
      chk("align_no_cyc", 32'(cyc_seen), 32'h0);
      chk("align_done_cnt", 32'(done_cnt), 32'h1);
      tick();
    end

    // Randomised copies, the last one wrapping the 32-bit address space.
    for (int it = 0; it < 6; it++) begin
      s = 32'h3800_0000 + ($urandom_range(0, 255) << 2);
      d = 32'h3800_4000 + ($urandom_range(0, 255) << 2);
      if (it == 5) s = 32'hFFFF_FFF8;
      len = $urandom_range(1, 6);
      rd_delay = $urandom_range(0, 3);
      wr_delay = $urandom_range(0, 3);
      seed = $urandom;
      start(s, d, len, 1'b1, 1'b1);
      finish_run("random", 2'd0, len, 1'b1);
    end

    // Read ack withheld: strobe lasts exactly TIMEOUT cycles.
    resp_en = 1'b0;
    start(32'h3800_0000, 32'h3800_4000, 2, 1'b0, 1'b1);
    finish_run("timeout", 2'd1, 0, 1'b0);
    chk("timeout_stb_len", 32'(last_run), 32'(TIMEOUT));
    resp_en = 1'b1;

    // Abort on the ack cycle of the second write.
    rd_delay = 1; wr_delay = 1; n_wr = 0; hit = 1'b0;
    start(32'h3800_0000, 32'h3800_4000, 4, 1'b1, 1'b1);
    for (int n = 0; n < 200 && !hit; n++) begin
      tick();
      hit = wbm_stb_o && wbm_we_o && (n_wr == 1);
    end
    chk("abort_reached_wr2", 32'(hit), 32'h1);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_bus_low", 32'(wbm_cyc_o), 32'h0);
    finish_run("abort", 2'd2, 1, 1'b0);

    // Start pulse while busy is ignored; stray acks while idle are ignored.
    rd_delay = 1; wr_delay = 1;
    start(32'h3800_0010, 32'h3800_4010, 2, 1'b1, 1'b1);
    repeat (3) tick();
    cfg_src = 32'h3800_0100; cfg_dst = 32'h3800_4100; cfg_len = LEN_W'(5);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    finish_run("busy_start", 2'd0, 2, 1'b1);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", 32'(sts_busy), 32'h0);
      chk("stray_cyc", 32'(wbm_cyc_o), 32'h0);
    end
    tick();
    force_ack = 1'b0;
    chk("stray_count", 32'(sts_count), 32'd2);
    chk("stray_done_cnt", 32'(done_cnt), 32'h1);

    // Synchronous reset in the middle of a write.
    rd_delay = 1; wr_delay = 3; hit = 1'b0;
    start(32'h3800_0000, 32'h3800_4000, 3, 1'b1, 1'b1);
    for (int n = 0; n < 200 && !hit; n++) begin
      tick();
      hit = wbm_stb_o && wbm_we_o;
    end
    chk("rstmid_reached_wr", 32'(hit), 32'h1);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rstmid_cyc", 32'(wbm_cyc_o), 32'h0);
    chk("rstmid_we", 32'(wbm_we_o), 32'h0);
    chk("rstmid_sel", 32'(wbm_sel_o), 32'h0);
    chk("rstmid_adr", wbm_adr_o, 32'h0);
    chk("rstmid_dat", wbm_dat_o, 32'h0);
    chk("rstmid_busy", 32'(sts_busy), 32'h0);
    chk("rstmid_done", 32'(sts_done), 32'h0);
    chk("rstmid_count", 32'(sts_count), 32'h0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_count = 0;
    prev_end = 1'b0;
    done_cnt = 0;
    mon_en = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_done", 32'(done_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
